// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: op codes and result-flag helper shared by the logic unit blocks
package logic_unit_pkg;
    localparam int MAX_W = 64;
    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_BUF  = 3'd7
    } op_e;
    typedef struct packed {
        logic zero;
        logic parity;
    } flags_t;
    // zero-extension keeps both flags exact for any width up to MAX_W
    function automatic flags_t flags_of(input logic [MAX_W-1:0] v);
        flags_t f;
        f.zero   = (v == '0);
        f.parity = ^v;
        return f;
    endfunction
endpackage

// File: rtl/logic_op_core.sv
// logic_op_core: combinational bitwise operation selected by op
module logic_op_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] result
);
    always_comb begin
        result = a;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_XOR:  result = a ^ b;
            OP_XNOR: result = ~(a ^ b);
            OP_NOT:  result = ~a;
            default: result = a;
        endcase
    end
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered logic op with valid/ready output, accumulator chain, flags and counter
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [2:0]         in_op,
    input  logic               in_chain,
    input  logic               acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_zero,
    output logic               out_parity,
    output logic [WIDTH-1:0]   acc,
    output logic [COUNT_W-1:0] txn_count
);
    logic [WIDTH-1:0]   data_q, data_d, acc_q, acc_d, acc_src, b_eff, result;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               valid_q, valid_d, zero_q, zero_d, par_q, par_d, accept;
    flags_t             flags;

    logic_op_core #(.WIDTH(WIDTH)) u_core (
        .a      (in_a),
        .b      (b_eff),
        .op     (op_e'(in_op)),
        .result (result)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign acc_src  = acc_clr ? '0 : acc_q;
    assign b_eff    = in_chain ? acc_src : in_b;
    assign flags    = flags_of(MAX_W'(result));

    // accept refills the output register even when it drains in the same cycle
    always_comb begin
        data_d  = accept ? result : data_q;
        zero_d  = accept ? flags.zero : zero_q;
        par_d   = accept ? flags.parity : par_q;
        valid_d = accept ? 1'b1 : (valid_q && !out_ready ? 1'b1 : 1'b0);
        acc_d   = accept ? result : (acc_clr ? '0 : acc_q);
        cnt_d   = accept ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            zero_q  <= 1'b1;
            par_q   <= 1'b0;
            valid_q <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            zero_q  <= zero_d;
            par_q   <= par_d;
            valid_q <= valid_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_zero   = zero_q;
    assign out_parity = par_q;
    assign acc        = acc_q;
    assign txn_count  = cnt_q;
endmodule
